// File: rtl/sonuc_paketleyici_pkg.sv
// Shared constants, types and address helpers for the result packer.
// Image size comes from IMG_WIDTH / IMG_HEIGHT macros when the build supplies them.
// Optional feature macro: SONUC_KIRP_EN (saturate results instead of slicing).
`ifndef IMG_WIDTH
`define IMG_WIDTH 16
`endif
`ifndef IMG_HEIGHT
`define IMG_HEIGHT 8
`endif

package sonuc_paketleyici_pkg;

  localparam int unsigned RES_BIT        = 12;
  localparam int unsigned PIXEL_BIT      = 8;
  localparam int unsigned SONUC_LANES    = 4;
  localparam int unsigned LANES          = SONUC_LANES;
  localparam int unsigned IMG_WIDTH      = `IMG_WIDTH;
  localparam int unsigned IMG_HEIGHT     = `IMG_HEIGHT;
  // One extra code point so an out-of-range coordinate is representable.
  localparam int unsigned IMG_WIDTH_BIT  = $clog2(IMG_WIDTH + 1);
  localparam int unsigned IMG_HEIGHT_BIT = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned ADDR_BIT       = $clog2(IMG_WIDTH * IMG_HEIGHT / LANES);
  localparam int unsigned LANE_BIT       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WORD_BIT       = LANES * PIXEL_BIT;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    TOPLA = 2'd1,
    YAZ   = 2'd2,
    BITTI = 2'd3
  } durum_t;

  // One accepted pixel, already reduced to its memory word coordinates.
  typedef struct packed {
    logic [ADDR_BIT-1:0]  adres;
    logic [LANE_BIT-1:0]  serit;
    logic [PIXEL_BIT-1:0] veri;
  } piksel_t;

  function automatic logic [ADDR_BIT-1:0] adres_hesapla(
    input logic [IMG_HEIGHT_BIT-1:0] row,
    input logic [IMG_WIDTH_BIT-1:0]  col
  );
    return ADDR_BIT'((32'(row) * IMG_WIDTH + 32'(col)) / LANES);
  endfunction

  function automatic logic [LANE_BIT-1:0] serit_hesapla(
    input logic [IMG_WIDTH_BIT-1:0] col
  );
    return LANE_BIT'(32'(col) % LANES);
  endfunction

endpackage

// File: rtl/sonuc_paketleyici_if.sv
// Filter result stream plus result memory write port of the packer.
interface sonuc_paketleyici_if;
  import sonuc_paketleyici_pkg::*;

  logic [RES_BIT-1:0]        res_veri_i;
  logic [IMG_HEIGHT_BIT-1:0] res_row_i;
  logic [IMG_WIDTH_BIT-1:0]  res_col_i;
  logic                      res_gecerli_i;
  logic                      res_hazir_o;
  logic                      res_bitti_i;
  logic [ADDR_BIT-1:0]       mem_adres_o;
  logic [WORD_BIT-1:0]       mem_veri_o;
  logic [LANES-1:0]          mem_maske_o;
  logic                      mem_gecerli_o;
  logic                      mem_hazir_i;

  // Upstream filter and memory side.
  modport master (
    output res_veri_i, res_row_i, res_col_i, res_gecerli_i, res_bitti_i, mem_hazir_i,
    input  res_hazir_o, mem_adres_o, mem_veri_o, mem_maske_o, mem_gecerli_o
  );

  // Packer side.
  modport slave (
    input  res_veri_i, res_row_i, res_col_i, res_gecerli_i, res_bitti_i, mem_hazir_i,
    output res_hazir_o, mem_adres_o, mem_veri_o, mem_maske_o, mem_gecerli_o
  );
endinterface

// File: rtl/sonuc_kirpici.sv
// Combinational RES_BIT -> PIXEL_BIT saturator; only exists when SONUC_KIRP_EN is defined.
`ifdef SONUC_KIRP_EN
module sonuc_kirpici
  import sonuc_paketleyici_pkg::*;
(
  input  logic [RES_BIT-1:0]   girdi,
  output logic [PIXEL_BIT-1:0] cikti_c
);

  // Negative clamps to 0, anything above the pixel range clamps to all-ones.
  always_comb begin
    cikti_c = girdi[PIXEL_BIT-1:0];
    if (girdi[RES_BIT-1]) begin
      cikti_c = '0;
    end else if (|girdi[RES_BIT-2:PIXEL_BIT]) begin
      cikti_c = '1;
    end
  end

endmodule
`endif

// File: rtl/sonuc_paketleyici.sv
// Packs LANES adjacent filter results of one row into a memory word and writes it out.
// Optional feature macro: SONUC_KIRP_EN (saturate results to the pixel range).
module sonuc_paketleyici
  import sonuc_paketleyici_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  sonuc_paketleyici_if.slave   bus,
  output logic                 bitti_o,
  output logic                 hata_o
);

  durum_t               durum_q, durum_d;
  logic [ADDR_BIT-1:0]  adres_q, adres_d;
  logic [WORD_BIT-1:0]  veri_q, veri_d;
  logic [LANES-1:0]     maske_q, maske_d;
  piksel_t              tut_q, tut_d;
  logic                 tut_gecerli_q, tut_gecerli_d;
  logic                 son_q, son_d;
  logic                 hata_q, hata_d;
  logic                 hazir_q, gecerli_q, bitti_q;

  logic [PIXEL_BIT-1:0] piksel_c;
  piksel_t              gelen_c;
  logic                 aktarim_c;
  logic                 kapsam_disi_c;

`ifdef SONUC_KIRP_EN
  sonuc_kirpici u_kirpici (
    .girdi   (bus.res_veri_i),
    .cikti_c (piksel_c)
  );
`else
  logic ust_bit_unused_c;
  assign piksel_c         = bus.res_veri_i[PIXEL_BIT-1:0];
  assign ust_bit_unused_c = ^bus.res_veri_i[RES_BIT-1:PIXEL_BIT];
`endif

  // Incoming pixel reduced to word address, lane and stored value.
  always_comb begin
    gelen_c.adres = adres_hesapla(bus.res_row_i, bus.res_col_i);
    gelen_c.serit = serit_hesapla(bus.res_col_i);
    gelen_c.veri  = piksel_c;
    kapsam_disi_c = (32'(bus.res_row_i) >= IMG_HEIGHT) || (32'(bus.res_col_i) >= IMG_WIDTH);
    aktarim_c     = bus.res_gecerli_i & hazir_q;
  end

  // Next-state and datapath update.
  always_comb begin
    durum_d       = durum_q;
    adres_d       = adres_q;
    veri_d        = veri_q;
    maske_d       = maske_q;
    tut_d         = tut_q;
    tut_gecerli_d = tut_gecerli_q;
    son_d         = son_q;
    hata_d        = hata_q;
    case (durum_q)
      BOSTA: durum_d = TOPLA;
      TOPLA: begin
        if (aktarim_c) begin
          if (kapsam_disi_c) begin
            hata_d = 1'b1;
          end else if ((maske_q == '0) ||
                       ((gelen_c.adres == adres_q) && !maske_q[gelen_c.serit])) begin
            adres_d = gelen_c.adres;
            veri_d[gelen_c.serit*PIXEL_BIT +: PIXEL_BIT] = gelen_c.veri;
            maske_d[gelen_c.serit] = 1'b1;
            if (maske_d == {LANES{1'b1}}) durum_d = YAZ;
          end else begin
            // Conflict: park the pixel and flush the open partial word first.
            tut_d         = gelen_c;
            tut_gecerli_d = 1'b1;
            durum_d       = YAZ;
          end
        end else if (bus.res_bitti_i) begin
          if (maske_q != '0) begin
            son_d   = 1'b1;
            durum_d = YAZ;
          end else begin
            durum_d = BITTI;
          end
        end
      end
      YAZ: begin
        if (bus.mem_hazir_i) begin
          maske_d = '0;
          veri_d  = '0;
          if (tut_gecerli_q) begin
            adres_d = tut_q.adres;
            veri_d[tut_q.serit*PIXEL_BIT +: PIXEL_BIT] = tut_q.veri;
            maske_d[tut_q.serit] = 1'b1;
            tut_gecerli_d = 1'b0;
            durum_d = (LANES == 1) ? YAZ : TOPLA;
          end else if (son_q) begin
            durum_d = BITTI;
          end else begin
            durum_d = TOPLA;
          end
        end
      end
      BITTI:   durum_d = BITTI;
      default: durum_d = BOSTA;
    endcase
  end

  // State, word buffer, hold register, flags and registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q       <= BOSTA;
      adres_q       <= '0;
      veri_q        <= '0;
      maske_q       <= '0;
      tut_q         <= '0;
      tut_gecerli_q <= 1'b0;
      son_q         <= 1'b0;
      hata_q        <= 1'b0;
      hazir_q       <= 1'b0;
      gecerli_q     <= 1'b0;
      bitti_q       <= 1'b0;
    end else begin
      durum_q       <= durum_d;
      adres_q       <= adres_d;
      veri_q        <= veri_d;
      maske_q       <= maske_d;
      tut_q         <= tut_d;
      tut_gecerli_q <= tut_gecerli_d;
      son_q         <= son_d;
      hata_q        <= hata_d;
      hazir_q       <= (durum_d == TOPLA);
      gecerli_q     <= (durum_d == YAZ);
      bitti_q       <= (durum_d == BITTI);
    end
  end

  assign bus.res_hazir_o   = hazir_q;
  assign bus.mem_gecerli_o = gecerli_q;
  assign bus.mem_adres_o   = adres_q;
  assign bus.mem_veri_o    = veri_q;
  assign bus.mem_maske_o   = maske_q;
  assign bitti_o           = bitti_q;
  assign hata_o            = hata_q;

endmodule

// File: tb/tb_sonuc_paketleyici.sv
// Directed bench for sonuc_paketleyici (16x8 image, 4 lanes).
module tb_sonuc_paketleyici;
  import sonuc_paketleyici_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bitti;
  logic hata;
  int   vektor = 0;
  int   hatali = 0;
  int   yazma  = 0;

`ifdef SONUC_KIRP_EN
  localparam logic [31:0] KIRP_BEKLENEN = 32'h7F80FF00;
`else
  localparam logic [31:0] KIRP_BEKLENEN = 32'h7F802CFB;
`endif

  sonuc_paketleyici_if bus ();

  sonuc_paketleyici dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .bitti_o (bitti),
    .hata_o  (hata)
  );

  always #5 clk = ~clk;

  // Counts write handshakes that will complete on the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (bus.mem_gecerli_o && bus.mem_hazir_i && !rst) yazma++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    vektor++;
    assert (gozlenen === beklenen) else begin
      hatali++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", etiket, gozlenen, beklenen);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic piksel(input logic [IMG_HEIGHT_BIT-1:0] r, input logic [IMG_WIDTH_BIT-1:0] c,
                        input logic [RES_BIT-1:0] v);
    int bekle;
    bekle = 0;
    bus.res_row_i     = r;
    bus.res_col_i     = c;
    bus.res_veri_i    = v;
    bus.res_gecerli_i = 1'b1;
    while (bus.res_hazir_o !== 1'b1 && bekle < 50) begin
      @(negedge clk);
      bekle++;
    end
    if (bekle >= 50) kontrol("hazir_bekle", 32'(bus.res_hazir_o), 32'd1);
    else @(posedge clk);
    @(negedge clk);
    bus.res_gecerli_i = 1'b0;
  endtask

  initial begin
    bus.res_veri_i    = '0;
    bus.res_row_i     = '0;
    bus.res_col_i     = '0;
    bus.res_gecerli_i = 1'b0;
    bus.res_bitti_i   = 1'b0;
    bus.mem_hazir_i   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    kontrol("rst_hazir",   32'(bus.res_hazir_o),   32'd0);
    kontrol("rst_gecerli", 32'(bus.mem_gecerli_o), 32'd0);
    kontrol("rst_adres",   32'(bus.mem_adres_o),   32'd0);
    kontrol("rst_veri",    32'(bus.mem_veri_o),    32'd0);
    kontrol("rst_maske",   32'(bus.mem_maske_o),   32'd0);
    kontrol("rst_bitti",   32'(bitti),             32'd0);
    kontrol("rst_hata",    32'(hata),              32'd0);
    rst = 1'b0;
    @(negedge clk);
    kontrol("basla_hazir", 32'(bus.res_hazir_o), 32'd1);

    // 1: full word row 0
    piksel(4'd0, 5'd0, 12'd10);
    piksel(4'd0, 5'd1, 12'd20);
    piksel(4'd0, 5'd2, 12'd30);
    piksel(4'd0, 5'd3, 12'd40);
    kontrol("t1_gecerli", 32'(bus.mem_gecerli_o), 32'd1);
    kontrol("t1_hazir",   32'(bus.res_hazir_o),   32'd0);
    kontrol("t1_adres",   32'(bus.mem_adres_o),   32'd0);
    kontrol("t1_veri",    32'(bus.mem_veri_o),    32'h281E140A);
    kontrol("t1_maske",   32'(bus.mem_maske_o),   32'hF);
    @(negedge clk);
    kontrol("t1_bos",     32'(bus.mem_gecerli_o), 32'd0);
    kontrol("t1_yazma",   32'(yazma),             32'd1);

    // 2: partial word flushed by an address conflict, parked pixel kept
    piksel(4'd1, 5'd4, 12'h11);
    piksel(4'd1, 5'd5, 12'h22);
    piksel(4'd1, 5'd8, 12'h33);
    kontrol("t2_gecerli", 32'(bus.mem_gecerli_o), 32'd1);
    kontrol("t2_adres",   32'(bus.mem_adres_o),   32'd5);
    kontrol("t2_maske",   32'(bus.mem_maske_o),   32'h3);
    kontrol("t2_veri",    32'(bus.mem_veri_o),    32'h00002211);
    @(negedge clk);
    kontrol("t2_bos",     32'(bus.mem_gecerli_o), 32'd0);
    kontrol("t2_yazma",   32'(yazma),             32'd2);
    piksel(4'd1, 5'd9,  12'h44);
    piksel(4'd1, 5'd10, 12'h55);
    piksel(4'd1, 5'd11, 12'h66);
    kontrol("t2b_gecerli", 32'(bus.mem_gecerli_o), 32'd1);
    kontrol("t2b_adres",   32'(bus.mem_adres_o),   32'd6);
    kontrol("t2b_veri",    32'(bus.mem_veri_o),    32'h66554433);
    kontrol("t2b_maske",   32'(bus.mem_maske_o),   32'hF);
    @(negedge clk);
    kontrol("t2b_yazma",   32'(yazma),             32'd3);

    // 3: memory back-pressure for 5 cycles
    bus.mem_hazir_i = 1'b0;
    piksel(4'd2, 5'd0, 12'd1);
    piksel(4'd2, 5'd1, 12'd2);
    piksel(4'd2, 5'd2, 12'd3);
    piksel(4'd2, 5'd3, 12'd4);
    for (int i = 0; i < 5; i++) begin
      kontrol("t3_gecerli", 32'(bus.mem_gecerli_o), 32'd1);
      kontrol("t3_hazir",   32'(bus.res_hazir_o),   32'd0);
      kontrol("t3_adres",   32'(bus.mem_adres_o),   32'd8);
      kontrol("t3_veri",    32'(bus.mem_veri_o),    32'h04030201);
      kontrol("t3_maske",   32'(bus.mem_maske_o),   32'hF);
      @(negedge clk);
    end
    kontrol("t3_c6_gecerli", 32'(bus.mem_gecerli_o), 32'd1);
    bus.mem_hazir_i = 1'b1;
    @(negedge clk);
    kontrol("t3_bos",   32'(bus.mem_gecerli_o), 32'd0);
    kontrol("t3_yazma", 32'(yazma),             32'd4);

    // 4: out-of-range column dropped, following pixels normal
    piksel(4'd3, 5'd16, 12'h77);
    kontrol("t4_hata",    32'(hata),              32'd1);
    kontrol("t4_gecerli", 32'(bus.mem_gecerli_o), 32'd0);
    kontrol("t4_hazir",   32'(bus.res_hazir_o),   32'd1);
    kontrol("t4_yazma",   32'(yazma),             32'd4);
    piksel(4'd3, 5'd0, 12'd5);
    piksel(4'd3, 5'd1, 12'd6);
    piksel(4'd3, 5'd2, 12'd7);
    piksel(4'd3, 5'd3, 12'd8);
    kontrol("t4_adres",   32'(bus.mem_adres_o),   32'd12);
    kontrol("t4_veri",    32'(bus.mem_veri_o),    32'h08070605);
    kontrol("t4_maske",   32'(bus.mem_maske_o),   32'hF);
    kontrol("t4_gecerli2", 32'(bus.mem_gecerli_o), 32'd1);
    @(negedge clk);
    kontrol("t4_yazma2",  32'(yazma),             32'd5);
    kontrol("t4_hata2",   32'(hata),              32'd1);

    // 5: end-of-stream flush then sticky done
    piksel(4'd4, 5'd0, 12'h0A);
    piksel(4'd4, 5'd1, 12'h0B);
    bus.res_bitti_i = 1'b1;
    @(negedge clk);
    kontrol("t5_gecerli", 32'(bus.mem_gecerli_o), 32'd1);
    kontrol("t5_maske",   32'(bus.mem_maske_o),   32'h3);
    kontrol("t5_adres",   32'(bus.mem_adres_o),   32'd16);
    kontrol("t5_veri",    32'(bus.mem_veri_o),    32'h00000B0A);
    kontrol("t5_bitti0",  32'(bitti),             32'd0);
    @(negedge clk);
    kontrol("t5_bitti",   32'(bitti),             32'd1);
    kontrol("t5_bos",     32'(bus.mem_gecerli_o), 32'd0);
    kontrol("t5_hazir",   32'(bus.res_hazir_o),   32'd0);
    kontrol("t5_yazma",   32'(yazma),             32'd6);
    repeat (3) @(negedge clk);
    kontrol("t5_bitti_kalici", 32'(bitti), 32'd1);
    kontrol("t5_yazma2",  32'(yazma),             32'd6);

    // 6: value reduction, then reset in the middle of a word
    bus.res_bitti_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_hazir_i = 1'b0;
    piksel(4'd0, 5'd0, 12'hFFB);
    piksel(4'd0, 5'd1, 12'd300);
    piksel(4'd0, 5'd2, 12'd128);
    piksel(4'd0, 5'd3, 12'h07F);
    kontrol("t6_veri",  32'(bus.mem_veri_o),  KIRP_BEKLENEN);
    kontrol("t6_adres", 32'(bus.mem_adres_o), 32'd0);
    kontrol("t6_bitti", 32'(bitti),           32'd0);
    bus.mem_hazir_i = 1'b1;
    @(negedge clk);
    kontrol("t6_yazma", 32'(yazma), 32'd7);

    piksel(4'd5, 5'd0, 12'h21);
    piksel(4'd5, 5'd1, 12'h22);
    rst = 1'b1;
    #1;
    kontrol("r_hazir",   32'(bus.res_hazir_o),   32'd0);
    kontrol("r_gecerli", 32'(bus.mem_gecerli_o), 32'd0);
    kontrol("r_maske",   32'(bus.mem_maske_o),   32'd0);
    kontrol("r_veri",    32'(bus.mem_veri_o),    32'd0);
    kontrol("r_adres",   32'(bus.mem_adres_o),   32'd0);
    kontrol("r_bitti",   32'(bitti),             32'd0);
    kontrol("r_hata",    32'(hata),              32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    kontrol("r_sonra_gecerli", 32'(bus.mem_gecerli_o), 32'd0);
    kontrol("r_sonra_hazir",   32'(bus.res_hazir_o),   32'd1);
    kontrol("r_sonra_yazma",   32'(yazma),             32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vektor, hatali);
    $finish;
  end

endmodule
